eth_pcs_tx_scrambler: RTL and testbench

- TX PCS stage between the 64b/66b encoder and the TX gearbox.
- Scrambles each 32-bit payload transfer with the self-synchronizing polynomial G(x)=1+x^39+x^58. The 2-bit sync header passes through unscrambled.
- Presents scrambled data and header to the gearbox in the same cycle the gearbox samples them, and advances scrambler state only when the gearbox accepts a transfer.
- Also provides a bypass mode, a scrambled-zeros test-pattern mode, and invalid-sync-header monitoring.

---
 rtl/eth_pcs_tx_scrambler.sv | 113 +++++++++++
 tb/tb_eth_pcs_tx_scrambler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_tx_scrambler.sv
// -----------------------------------------------------------------------------
// eth_pcs_tx_scrambler
//
// TX PCS scrambler between the 64b/66b encoder and the TX gearbox.
// The 32-bit payload is scrambled with the self-synchronizing polynomial
// G(x) = 1 + x^39 + x^58. The 2-bit sync header is not scrambled.
// Scrambled data is produced combinationally from the current state, so the
// gearbox samples it in the same cycle. The state only advances on cycles
// where the gearbox accepts a transfer (i_clk_en).
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous, active-high reset
//   i_clk_en     gearbox accept strobe; the transfer is consumed when 1
//   i_trans_cnt  transfer index inside the 66-bit block (0 = first)
//   i_mode       00 normal, 01 bypass, 10 scrambled-zeros test, 11 normal
//   i_sync_data  encoder sync header, meaningful when i_trans_cnt == 0
//   i_enc_data   encoder payload, bit 0 transmitted first
//   o_sync_data  sync header to the gearbox (combinational)
//   o_scr_data   scrambled payload to the gearbox (combinational)
//   o_sync_err   one-cycle pulse after an invalid header is accepted
//   o_err_cnt    saturating count of invalid headers
// -----------------------------------------------------------------------------
module eth_pcs_tx_scrambler #(
    parameter int          W_DATA          = 32,
    parameter int          W_SYNC          = 2,
    parameter int          W_TRANS_PER_BLK = 1,
    parameter logic [57:0] SCR_SEED        = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int          W_ERR_CNT       = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clk_en,
    input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
    input  logic [1:0]                 i_mode,
    input  logic [W_SYNC-1:0]          i_sync_data,
    input  logic [W_DATA-1:0]          i_enc_data,
    output logic [W_SYNC-1:0]          o_sync_data,
    output logic [W_DATA-1:0]          o_scr_data,
    output logic                       o_sync_err,
    output logic [W_ERR_CNT-1:0]       o_err_cnt
);

    localparam int         W_SCR       = 58;
    localparam int         TAP_A       = 38;   // x^39 term
    localparam int         TAP_B       = 57;   // x^58 term
    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_BYPASS = 2'b01;
    localparam logic [1:0] MODE_TEST   = 2'b10;
    localparam logic [1:0] MODE_NORM_B = 2'b11;

    // Scrambler state: bit 0 holds the most recently scrambled bit.
    logic [W_SCR-1:0]     scr_reg;
    logic [W_SCR-1:0]     scr_next;
    logic [W_DATA-1:0]    data_src;
    logic [W_DATA-1:0]    scr_word;

    logic                 sync_err_reg;
    logic [W_ERR_CNT-1:0] err_cnt_reg;
    logic                 sync_chk_en;
    logic                 sync_invalid;
    logic                 sync_err_next;

    // Test mode scrambles an all-zero payload regardless of encoder input.
    assign data_src = (i_mode == MODE_TEST) ? '0 : i_enc_data;

    // Bit-serial scrambler unrolled over the whole transfer. Each bit sees
    // the state already shifted by all earlier bits of the same word.
    always_comb begin
        logic [W_SCR-1:0] s_work;
        logic             y_bit;
        s_work   = scr_reg;
        y_bit    = 1'b0;
        scr_word = '0;
        for (int i = 0; i < W_DATA; i++) begin
            y_bit       = data_src[i] ^ s_work[TAP_A] ^ s_work[TAP_B];
            scr_word[i] = y_bit;
            s_work      = {s_work[W_SCR-2:0], y_bit};
        end
        scr_next = s_work;
    end

    // Bypass only affects the output; the state keeps tracking the scrambled
    // stream so that returning to normal mode needs no re-seed.
    assign o_scr_data  = (i_mode == MODE_BYPASS) ? i_enc_data : scr_word;
    assign o_sync_data = (i_mode == MODE_TEST) ? W_SYNC'(1) : i_sync_data;

    // Only accepted first-transfer headers in the normal modes are checked.
    assign sync_chk_en   = ((i_mode == MODE_NORMAL) || (i_mode == MODE_NORM_B))
                           && i_clk_en && (i_trans_cnt == '0);
    assign sync_invalid  = (i_sync_data == '0) || (i_sync_data == '1);
    assign sync_err_next = sync_chk_en && sync_invalid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            scr_reg      <= SCR_SEED;
            sync_err_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            if (i_clk_en) begin
                scr_reg <= scr_next;
            end
            sync_err_reg <= sync_err_next;
            if (sync_err_next && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + W_ERR_CNT'(1);
            end
        end
    end

    assign o_sync_err = sync_err_reg;
    assign o_err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_eth_pcs_tx_scrambler.sv
// -----------------------------------------------------------------------------
// tb_eth_pcs_tx_scrambler
//
// Directed bench for eth_pcs_tx_scrambler. Expected scrambler words for the
// all-zero payload after a seed reload were derived by hand from the
// recurrence y[k] = d[k] ^ y[k-39] ^ y[k-58] with an all-ones seed:
//   word0 = 0000_0000, word1 = 03FF_FF80, word2 = FFFF_C000, word3 = FFEF_FFFF
// A second instance with a 4-bit error counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_eth_pcs_tx_scrambler;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [0:0]  trans_cnt;
    logic [1:0]  mode;
    logic [1:0]  sync_in;
    logic [31:0] enc_data;

    logic [1:0]  sync_out;
    logic [31:0] scr_data;
    logic        sync_err;
    logic [15:0] err_cnt;

    logic [1:0]  small_sync_out;
    logic [31:0] small_scr_data;
    logic        small_sync_err;
    logic [3:0]  small_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    eth_pcs_tx_scrambler dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clk_en    (clk_en),
        .i_trans_cnt (trans_cnt),
        .i_mode      (mode),
        .i_sync_data (sync_in),
        .i_enc_data  (enc_data),
        .o_sync_data (sync_out),
        .o_scr_data  (scr_data),
        .o_sync_err  (sync_err),
        .o_err_cnt   (err_cnt)
    );

    eth_pcs_tx_scrambler #(.W_ERR_CNT(4)) dut_small (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clk_en    (clk_en),
        .i_trans_cnt (trans_cnt),
        .i_mode      (mode),
        .i_sync_data (sync_in),
        .i_enc_data  (enc_data),
        .o_sync_data (small_sync_out),
        .o_scr_data  (small_scr_data),
        .o_sync_err  (small_sync_err),
        .o_err_cnt   (small_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        clk_en    = 1'b1;
        trans_cnt = 1'b0;
        tick();
        reset     = 1'b0;
    endtask

    // Check the four hand-derived zero-payload words, accepting each one.
    task automatic zero_block_pair(input string tag);
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0000_0000;
        exp_w[1] = 32'h03FF_FF80;
        exp_w[2] = 32'hFFFF_C000;
        exp_w[3] = 32'hFFEF_FFFF;
        for (int w = 0; w < 4; w++) begin
            trans_cnt = w[0];
            #1;
            check($sformatf("%s_w%0d", tag, w), {32'h0, scr_data}, {32'h0, exp_w[w]});
            tick();
        end
    endtask

    initial begin
        logic [57:0] hist;
        logic [31:0] rec;
        logic        ybit;
        int          cyc;
        int          words;

        reset     = 1'b1;
        clk_en    = 1'b1;
        trans_cnt = 1'b0;
        mode      = 2'b00;
        sync_in   = 2'b01;
        enc_data  = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state of the registered outputs.
        check("rst_sync_err", {63'h0, sync_err}, 64'h0);
        check("rst_err_cnt", {48'h0, err_cnt}, 64'h0);

        // Seed check, unstalled stream.
        zero_block_pair("seed");

        // Stall for three cycles on word1, then continue.
        do_reset();
        trans_cnt = 1'b0;
        #1;
        check("stall_w0", {32'h0, scr_data}, 64'h0);
        tick();
        trans_cnt = 1'b1;
        clk_en    = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check($sformatf("stall_hold%0d", s), {32'h0, scr_data}, 64'h03FF_FF80);
            tick();
        end
        clk_en = 1'b1;
        #1;
        check("stall_w1", {32'h0, scr_data}, 64'h03FF_FF80);
        tick();
        trans_cnt = 1'b0;
        #1;
        check("stall_w2", {32'h0, scr_data}, 64'hFFFF_C000);
        tick();
        trans_cnt = 1'b1;
        #1;
        check("stall_w3", {32'h0, scr_data}, 64'hFFEF_FFFF);
        tick();

        // Bypass mode.
        do_reset();
        mode     = 2'b01;
        sync_in  = 2'b10;
        enc_data = 32'hDEAD_BEEF;
        #1;
        check("bypass_data", {32'h0, scr_data}, 64'hDEAD_BEEF);
        check("bypass_sync", {62'h0, sync_out}, 64'h2);
        tick();

        // Scrambled-zeros test mode ignores the encoder.
        do_reset();
        mode      = 2'b10;
        sync_in   = 2'b10;
        enc_data  = 32'hFFFF_FFFF;
        trans_cnt = 1'b0;
        #1;
        check("test_sync", {62'h0, sync_out}, 64'h1);
        check("test_w0", {32'h0, scr_data}, 64'h0);
        tick();
        trans_cnt = 1'b1;
        #1;
        check("test_w1", {32'h0, scr_data}, 64'h03FF_FF80);
        tick();
        mode     = 2'b00;
        sync_in  = 2'b01;
        enc_data = 32'h0;

        // Sync error detection and counting.
        do_reset();
        trans_cnt = 1'b0;
        sync_in   = 2'b11;
        #1;
        check("serr_pre", {63'h0, sync_err}, 64'h0);
        tick();
        sync_in   = 2'b01;
        trans_cnt = 1'b1;
        #1;
        check("serr_pulse", {63'h0, sync_err}, 64'h1);
        check("serr_cnt1", {48'h0, err_cnt}, 64'h1);
        tick();
        check("serr_drop", {63'h0, sync_err}, 64'h0);
        check("serr_cnt1b", {48'h0, err_cnt}, 64'h1);
        sync_in   = 2'b11;
        trans_cnt = 1'b1;
        tick();
        check("serr_tc1", {48'h0, err_cnt}, 64'h1);
        trans_cnt = 1'b0;
        clk_en    = 1'b0;
        tick();
        check("serr_stall", {48'h0, err_cnt}, 64'h1);
        check("serr_stall_p", {63'h0, sync_err}, 64'h0);
        clk_en  = 1'b1;
        mode    = 2'b01;
        sync_in = 2'b00;
        tick();
        check("serr_bypass", {48'h0, err_cnt}, 64'h1);
        mode = 2'b11;
        tick();
        check("serr_mode11", {48'h0, err_cnt}, 64'h2);
        check("serr_mode11_p", {63'h0, sync_err}, 64'h1);
        mode = 2'b00;

        // Saturation on the 4-bit instance (already at 2).
        sync_in = 2'b11;
        for (int e = 0; e < 20; e++) tick();
        sync_in = 2'b01;
        tick();
        check("sat_main_cnt", {48'h0, err_cnt}, 64'd22);
        check("sat_small_cnt", {60'h0, small_err_cnt}, 64'hF);
        sync_in = 2'b11;
        tick();
        check("sat_small_hold", {60'h0, small_err_cnt}, 64'hF);
        check("sat_small_pulse", {63'h0, small_sync_err}, 64'h1);
        sync_in = 2'b01;

        // Reset asserted on word1 of a block.
        enc_data  = 32'h0;
        trans_cnt = 1'b0;
        tick();
        trans_cnt = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_err_cnt", {48'h0, err_cnt}, 64'h0);
        check("mrst_small_cnt", {60'h0, small_err_cnt}, 64'h0);
        check("mrst_sync_err", {63'h0, sync_err}, 64'h0);
        trans_cnt = 1'b0;
        #1;
        check("mrst_w0", {32'h0, scr_data}, 64'h0);
        tick();
        trans_cnt = 1'b1;
        #1;
        check("mrst_w1", {32'h0, scr_data}, 64'h03FF_FF80);
        tick();

        // Round trip over 1000 blocks with periodic gearbox stalls.
        do_reset();
        mode      = 2'b00;
        trans_cnt = 1'b0;
        enc_data  = $urandom;
        sync_in   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        hist      = '0;
        cyc       = 0;
        words     = 0;
        while (words < 2000) begin
            cyc++;
            clk_en = ((cyc % 33) != 0);
            #1;
            if (trans_cnt == 1'b0) begin
                check($sformatf("rt_hdr_%0d", words), {62'h0, sync_out}, {62'h0, sync_in});
            end
            if (clk_en) begin
                rec = '0;
                for (int b = 0; b < 32; b++) begin
                    ybit   = scr_data[b];
                    rec[b] = ybit ^ hist[38] ^ hist[57];
                    hist   = {hist[56:0], ybit};
                end
                if (words >= 2) begin
                    check($sformatf("rt_data_%0d", words), {32'h0, rec}, {32'h0, enc_data});
                end
                words++;
            end
            tick();
            if (clk_en) begin
                trans_cnt = ~trans_cnt;
                enc_data  = $urandom;
                if (trans_cnt == 1'b0) begin
                    sync_in = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
